mealy_zero_detector: RTL and testbench



---
 rtl/mealy_zero_detector_pkg.sv | 18 +
 rtl/mealy_zero_detector_if.sv | 11 +
 rtl/mealy_zero_detector.sv | 49 ++++
 tb/tb_mealy_zero_detector.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mealy_zero_detector_pkg.sv
// Shared state encoding for the Mealy zero detector.
package mealy_zero_detector_pkg;

    // Fixed 2-bit encodings; kept as plain constants so legacy code can use them directly.
    localparam logic [1:0] ENC_S0 = 2'b00;
    localparam logic [1:0] ENC_S1 = 2'b01;
    localparam logic [1:0] ENC_S2 = 2'b10;
    localparam logic [1:0] ENC_S3 = 2'b11;

    // S0 idle, S1 one '1' seen, S3 two '1's seen, S2 three or more '1's seen.
    typedef enum logic [1:0] {
        S0 = ENC_S0,
        S1 = ENC_S1,
        S2 = ENC_S2,
        S3 = ENC_S3
    } state_e;

endpackage

// File: rtl/mealy_zero_detector_if.sv
// Serial bit-stream connection to the zero detector.
// master drives the serial bit and watches the detect flag; slave is the detector side.
// There is no handshake: x_in is sampled on every rising clock edge and y_out is a
// live combinational flag, valid whenever the detector is out of reset.
interface mealy_zero_detector_if;
    logic x_in;
    logic y_out;

    modport master (output x_in, input  y_out);
    modport slave  (input  x_in, output y_out);
endinterface

// File: rtl/mealy_zero_detector.sv
// Mealy FSM: y_out is high while x_in is 0 after a run of consecutively sampled 1s.
// The output is combinational from the current state and the live input, so it may
// change between clock edges; only the value of x_in at a rising edge moves the state.
module mealy_zero_detector
    import mealy_zero_detector_pkg::*;
(
    output logic y_out,
    input  logic x_in,
    input  logic clock,
    input  logic reset
);

    state_e r_state;
    state_e w_next;
    logic   w_y;

    // State register; reset low forces S0 immediately and holds it, ignoring clock edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: any 0 returns to idle, 1s walk S0->S1->S3->S2 and saturate in S2.
    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = x_in ? S1 : S0;
            S1:      w_next = x_in ? S3 : S0;
            S3:      w_next = x_in ? S2 : S0;
            S2:      w_next = x_in ? S2 : S0;
            default: w_next = S0;
        endcase
    end

    // Output: a 0 on the live input while any 1s are pending; an unknown state decodes as idle.
    always_comb begin
        w_y = 1'b0;
        case (r_state)
            S1, S2, S3: w_y = ~x_in;
            default:    w_y = 1'b0;
        endcase
    end

    assign y_out = w_y;

endmodule

// File: tb/tb_mealy_zero_detector.sv
// Directed bench for the Mealy zero detector with an expected-value queue.
module tb_mealy_zero_detector;

    logic clock;
    logic reset;

    mealy_zero_detector_if zd_if();

    mealy_zero_detector dut (
        .y_out (zd_if.y_out),
        .x_in  (zd_if.x_in),
        .clock (clock),
        .reset (reset)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: each entry is {state[1:0], y_out}
    logic [2:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    // Drive the serial input
    task automatic drive_x(input logic v);
        zd_if.x_in = v;
    endtask

    // Advance past the next rising edge and settle 1 ns after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Queue the expectation for the current stimulus, let it settle, then compare
    task automatic check(input string tag, input logic [1:0] exp_s, input logic exp_y);
        logic [2:0] obs;
        logic [2:0] exp;
        exp_q.push_back({exp_s, exp_y});
        #1;
        obs = {dut.r_state, zd_if.y_out};
        exp = exp_q.pop_front();
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed state=%0d y_out=%b, expected state=%0d y_out=%b",
                    tag, obs[2:1], obs[0], exp[2:1], exp[0]);
    endtask

    initial begin
        // Reset held low: clock edges ignored, y_out low for either x_in value
        reset = 1'b0;
        drive_x(1'bx);
        check("rst_xx", 2'd0, 1'b0);
        drive_x(1'b0);
        check("rst_x0", 2'd0, 1'b0);
        drive_x(1'b1);
        check("rst_x1", 2'd0, 1'b0);
        tick();
        check("rst_edge1", 2'd0, 1'b0);
        tick();
        drive_x(1'b0);
        check("rst_edge2", 2'd0, 1'b0);

        // Release reset between edges, run of ones S1 -> S3 -> S2 -> S2
        reset = 1'b1;
        drive_x(1'b1);
        check("rel_idle", 2'd0, 1'b0);
        tick();
        check("run_s1", 2'd1, 1'b0);
        tick();
        check("run_s3", 2'd3, 1'b0);
        tick();
        check("run_s2", 2'd2, 1'b0);
        tick();
        check("run_s2_hold", 2'd2, 1'b0);
        drive_x(1'b0);
        check("run_zero_imm", 2'd2, 1'b1);
        tick();
        check("run_zero_edge", 2'd0, 1'b0);

        // Single one
        drive_x(1'b1);
        tick();
        check("one_s1", 2'd1, 1'b0);
        drive_x(1'b0);
        check("one_zero_imm", 2'd1, 1'b1);
        tick();
        check("one_zero_edge", 2'd0, 1'b0);

        // Glitches between edges in S3: output follows ~x_in, state unchanged
        drive_x(1'b1);
        tick();
        tick();
        drive_x(1'b0);
        check("glitch_s3_lo", 2'd3, 1'b1);
        drive_x(1'b1);
        check("glitch_s3_hi", 2'd3, 1'b0);
        drive_x(1'b0);
        check("glitch_s3_lo2", 2'd3, 1'b1);
        drive_x(1'b1);
        tick();
        check("glitch_to_s2", 2'd2, 1'b0);

        // Async reset mid-run from S2 with y_out high
        drive_x(1'b0);
        check("arst_pre", 2'd2, 1'b1);
        reset = 1'b0;
        check("arst_now", 2'd0, 1'b0);
        drive_x(1'b1);
        tick();
        check("arst_edge_ign", 2'd0, 1'b0);
        reset = 1'b1;
        check("arst_release", 2'd0, 1'b0);
        tick();
        check("arst_to_s1", 2'd1, 1'b0);

        // Zeros only: back to S0, then five edges of 0
        drive_x(1'b0);
        tick();
        check("zeros_enter", 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("zeros_%0d", i), 2'd0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
